mem_stall_responder: RTL and testbench

Cycle-accurate memory responder for the core's instruction or data memory port. It sits directly upstream of the core and its design-assertion modules: it drives `gnt`, `err` and `rdata` back to the core. It inserts pseudo-random wait states to stress the request/grant handshake. It also flags any request-side protocol violation it sees. Instantiate one per port (imem, dmem).

---
 rtl/mem_stall_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_stall_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_responder.sv
// Memory responder for one core port: a backing word array behind a req/gnt
// handshake, with LFSR-driven wait states and a sticky request-protocol flag.
module mem_stall_responder #(
    parameter int                    MEM_ADDR_W = 64,
    parameter int                    MEM_DATA_W = 64,
    parameter int                    DEPTH_W    = 10,
    parameter logic [MEM_ADDR_W-1:0] BASE       = 64'h0,
    parameter bit                    STALL_EN   = 1'b1,
    parameter int                    STALL_W    = 3,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    g_resetn,
    input  logic                    req,
    input  logic [MEM_ADDR_W-1:0]   addr,
    input  logic                    wen,
    input  logic [MEM_DATA_W/8-1:0] strb,
    input  logic [MEM_DATA_W-1:0]   wdata,
    output logic                    gnt,
    output logic                    err,
    output logic [MEM_DATA_W-1:0]   rdata,
    output logic                    proto_err,
    output logic [STALL_W-1:0]      stall_cnt
);

    localparam int STRB_W = MEM_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORDS  = 2 ** DEPTH_W;
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
    logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                    gnt_q, gnt_d;
    logic                    err_q, err_d;
    logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    proto_err_q, proto_err_d;

    logic [MEM_DATA_W-1:0]   mem_array [WORDS];

    logic [MEM_ADDR_W-1:0]   cur_addr_s;
    logic                    cur_wen_s;
    logic [MEM_ADDR_W-1:0]   offset_s;
    logic                    in_range_s;
    logic [DEPTH_W-1:0]      idx_s;
    logic                    req_mismatch_s;
    logic [STALL_W-1:0]      load_stall_s;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // Address decode: in IDLE the incoming request is used directly so that
    // a zero-stall read can still be registered on the cycle before RESP.
    always_comb begin
        cur_addr_s     = (state_q == ST_IDLE) ? addr : addr_q;
        cur_wen_s      = (state_q == ST_IDLE) ? wen  : wen_q;
        offset_s       = cur_addr_s - BASE;
        in_range_s     = (cur_addr_s >= BASE) && ((offset_s >> (OFF_W + DEPTH_W)) == '0);
        idx_s          = offset_s[OFF_W +: DEPTH_W];
        req_mismatch_s = (addr != addr_q) || (wen != wen_q) ||
                         (strb != strb_q) || (wdata != wdata_q);
        load_stall_s   = STALL_EN ? lfsr_q[STALL_W-1:0] : '0;
    end

    // Next-state, capture, protocol check and registered response values
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_step(lfsr_q);
        addr_d      = addr_q;
        wen_d       = wen_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        stall_cnt_d = stall_cnt_q;
        proto_err_d = proto_err_q;
        gnt_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d      = addr;
                    wen_d       = wen;
                    strb_d      = strb;
                    wdata_d     = wdata;
                    stall_cnt_d = load_stall_s;
                    state_d     = (load_stall_s == '0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    stall_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q - STALL_ONE;
                    state_d     = (stall_cnt_q == STALL_ONE) ? ST_RESP : ST_WAIT;
                end
            end
            ST_RESP: begin
                stall_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                stall_cnt_d = '0;
                state_d     = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && (!req || req_mismatch_s)) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end

        if (state_d == ST_RESP) begin
            gnt_d   = 1'b1;
            err_d   = !in_range_s;
            rdata_d = (in_range_s && !cur_wen_s) ? mem_array[idx_s] : '0;
        end else begin
            gnt_d   = 1'b0;
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            strb_q      <= '0;
            wdata_q     <= '0;
            stall_cnt_q <= '0;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            stall_cnt_q <= stall_cnt_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Byte-lane write commits at the end of the response cycle; the array is not reset
    always_ff @(posedge clock) begin
        if ((state_q == ST_RESP) && wen_q && in_range_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb_q[i]) begin
                    mem_array[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign gnt       = gnt_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign proto_err = proto_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Directed bench: one responder without stalls, one with LFSR stalls, both
// checked against hand-computed values and a reference LFSR.
module tb_mem_stall_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        g_resetn = 1'b0;
    logic        req0, req1, wen;
    logic [63:0] addr, wdata;
    logic [7:0]  strb;
    logic        gnt0, err0, pe0, gnt1, err1, pe1;
    logic [63:0] rdata0, rdata1;
    logic [2:0]  sc0, sc1;
    logic [15:0] m_lfsr;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_stall_responder #(.BASE(BASE), .STALL_EN(1'b0)) u_dut (
        .clock(clock), .g_resetn(g_resetn), .req(req0), .addr(addr), .wen(wen),
        .strb(strb), .wdata(wdata), .gnt(gnt0), .err(err0), .rdata(rdata0),
        .proto_err(pe0), .stall_cnt(sc0)
    );

    mem_stall_responder #(.BASE(BASE), .STALL_EN(1'b1)) u_dut_s (
        .clock(clock), .g_resetn(g_resetn), .req(req1), .addr(addr), .wen(wen),
        .strb(strb), .wdata(wdata), .gnt(gnt1), .err(err1), .rdata(rdata1),
        .proto_err(pe1), .stall_cnt(sc1)
    );

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
        logic b;
        b = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {b, v[15:1]};
    endfunction

    always @(posedge clock or negedge g_resetn) begin
        if (!g_resetn) m_lfsr <= 16'hACE1;
        else           m_lfsr <= ref_lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, wait (bounded) for gnt, hold through the RESP cycle, then release.
    task automatic txn(input bit sel, input logic w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, output int lat, output logic e, output logic [63:0] rd);
        addr = a; wen = w; strb = s; wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        lat = -1; e = 1'b0; rd = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if ((sel ? gnt1 : gnt0) === 1'b1) begin
                lat = k;
                e   = sel ? err1 : err0;
                rd  = sel ? rdata1 : rdata0;
            end
        end
        check("gnt_seen", lat > 0, 64'd1);
        tick();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // Advance until the stalling responder would load a stall of 3 this cycle.
    task automatic wait_stall3();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (m_lfsr[2:0] == 3'd3) found = 1'b1;
            else tick();
        end
        check("stall3_found", found, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, maxlat, exp_s;
        logic        e;
        logic [63:0] rd;
        bit          saw0, saw7;

        req0 = 1'b0; req1 = 1'b0; wen = 1'b0; strb = 8'h00; addr = BASE; wdata = 64'd0;
        u_dut.mem_array[0]   = 64'hA5A5_0000_5A5A_FFFF;
        u_dut.mem_array[3]   = 64'h1122_3344_5566_7788;
        u_dut_s.mem_array[5] = 64'hDEAD_BEEF_CAFE_F00D;
        u_dut_s.mem_array[7] = 64'h0123_4567_89AB_CDEF;

        repeat (3) @(posedge clock);
        #1;
        check("rst_gnt", gnt0, 64'd0);
        check("rst_err", err0, 64'd0);
        check("rst_rdata", rdata0, 64'd0);
        check("rst_proto", pe0, 64'd0);
        check("rst_stall_cnt", sc1, 64'd0);
        check("rst_lfsr", u_dut_s.lfsr_q, 64'hACE1);
        g_resetn = 1'b1;
        tick();

        // Read without stall, then a back-to-back second read
        addr = BASE + 64'd24; wen = 1'b0; req0 = 1'b1;
        tick();
        check("read_gnt", gnt0, 64'd1);
        check("read_rdata", rdata0, 64'h1122_3344_5566_7788);
        check("read_err", err0, 64'd0);
        tick();
        check("b2b_gap_gnt", gnt0, 64'd0);
        check("b2b_gap_rdata", rdata0, 64'd0);
        tick();
        check("b2b_second_gnt", gnt0, 64'd1);
        tick();
        req0 = 1'b0;

        // Strobed write then read back
        txn(1'b0, 1'b1, BASE + 64'd24, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, lat, e, rd);
        check("wr_latency", lat, 64'd1);
        check("wr_rdata_zero", rd, 64'd0);
        txn(1'b0, 1'b0, BASE + 64'd24, 8'h00, 64'd0, lat, e, rd);
        check("wr_readback", rd, 64'h1122_3344_FFFF_FFFF);

        // Out-of-range read and write
        txn(1'b0, 1'b0, BASE + 64'd8192, 8'h00, 64'd0, lat, e, rd);
        check("oor_rd_err", e, 64'd1);
        check("oor_rd_rdata", rd, 64'd0);
        txn(1'b0, 1'b1, BASE + 64'd8192, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, lat, e, rd);
        check("oor_wr_err", e, 64'd1);
        txn(1'b0, 1'b0, BASE, 8'h00, 64'd0, lat, e, rd);
        check("oor_word0_intact", rd, 64'hA5A5_0000_5A5A_FFFF);
        check("oor_word0_err", e, 64'd0);
        check("nostall_proto_clean", pe0, 64'd0);

        // 200 back-to-back reads with LFSR stalls
        addr = BASE + 64'd56; wen = 1'b0; strb = 8'h00; wdata = 64'd0;
        req1 = 1'b1;
        maxlat = 0; saw0 = 1'b0; saw7 = 1'b0;
        for (int t = 0; t < 200; t++) begin
            exp_s = int'(m_lfsr[2:0]);
            lat = -1;
            for (int k = 1; k <= 12 && lat < 0; k++) begin
                tick();
                if (gnt1 === 1'b1) lat = k;
            end
            check("stall_latency", lat, exp_s + 1);
            check("stall_rdata", rdata1, 64'h0123_4567_89AB_CDEF);
            if (lat > maxlat) maxlat = lat;
            if (lat == 1) saw0 = 1'b1;
            if (lat == 8) saw7 = 1'b1;
            tick();
        end
        req1 = 1'b0;
        check("stall_max_le_8", maxlat <= 8, 64'd1);
        check("stall_saw_zero", saw0, 64'd1);
        check("stall_saw_max", saw7, 64'd1);
        check("stall_proto_clean", pe1, 64'd0);
        tick();

        // Address change during a forced stall of 3
        wait_stall3();
        req1 = 1'b1; addr = BASE + 64'd56;
        tick();
        check("forced_stall_cnt", sc1, 64'd3);
        check("pe_before", pe1, 64'd0);
        addr = BASE + 64'd64;
        tick();
        check("pe_addr_change", pe1, 64'd1);
        addr = BASE + 64'd56;
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            tick();
            if (gnt1 === 1'b1) lat = k;
        end
        check("pe_txn_gnt", lat, 64'd2);
        tick();
        req1 = 1'b0;
        repeat (3) tick();
        check("pe_sticky", pe1, 64'd1);

        // Request dropped in WAIT
        wait_stall3();
        req1 = 1'b1;
        tick();
        check("drop_in_wait", sc1, 64'd3);
        req1 = 1'b0;
        tick();
        check("drop_stall_cnt", sc1, 64'd0);
        check("drop_state_idle", u_dut_s.state_q, 64'd0);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (gnt1 === 1'b1) lat = 1;
            tick();
        end
        check("drop_no_gnt", lat, 64'd0);

        // Reset during WAIT of a write
        wait_stall3();
        req1 = 1'b1; wen = 1'b1; addr = BASE + 64'd40; strb = 8'hFF; wdata = 64'd0;
        tick();
        check("rstw_in_wait", sc1, 64'd3);
        g_resetn = 1'b0;
        #1;
        check("rstw_gnt", gnt1, 64'd0);
        check("rstw_stall_cnt", sc1, 64'd0);
        check("rstw_lfsr", u_dut_s.lfsr_q, 64'hACE1);
        check("rstw_proto_clr", pe1, 64'd0);
        req1 = 1'b0; wen = 1'b0;
        tick();
        g_resetn = 1'b1;
        tick();
        txn(1'b1, 1'b0, BASE + 64'd40, 8'h00, 64'd0, lat, e, rd);
        check("rstw_word_intact", rd, 64'hDEAD_BEEF_CAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
